// File: rtl/alu_cmd_issue_pkg.sv
// Shared types and default widths for the ALU command issue slice.
package alu_issue_pkg;
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned OP_W_DEF   = 3;

   typedef struct packed {
      logic [DATA_W_DEF-1:0] in_1;
      logic [DATA_W_DEF-1:0] in_2;
      logic [OP_W_DEF-1:0]   op;
      logic                  fwd;
   } alu_cmd_t;
endpackage

// File: rtl/alu_cmd_issue_if.sv
// Command-in and result-out handshake bundle of the ALU issue stage.
interface alu_cmd_issue_if;
   import alu_issue_pkg::*;

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [DATA_W_DEF-1:0] cmd_in_1;
   logic [DATA_W_DEF-1:0] cmd_in_2;
   logic [OP_W_DEF-1:0]   cmd_op;
   logic                  cmd_fwd;
   logic                  res_valid;
   logic                  res_ready;
   logic [DATA_W_DEF-1:0] res_data;

   modport master (
      output cmd_valid, cmd_in_1, cmd_in_2, cmd_op, cmd_fwd, res_ready,
      input  cmd_ready, res_valid, res_data
   );

   modport slave (
      input  cmd_valid, cmd_in_1, cmd_in_2, cmd_op, cmd_fwd, res_ready,
      output cmd_ready, res_valid, res_data
   );
endinterface

// File: rtl/alu_cmd_issue_fifo.sv
// Power-of-two command FIFO with occupancy count; head is shown combinationally.
module alu_cmd_fifo
   import alu_issue_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  alu_cmd_t                 din,
   input  logic                     pop,
   output alu_cmd_t                 dout,
   output logic                     empty_c,
   output logic                     full_c,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   alu_cmd_t         mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Pointers wrap naturally at PTR_W bits since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign dout    = mem[rd_ptr];
   assign empty_c = (count == '0);
   assign full_c  = (count == CNT_W'(DEPTH));
endmodule

// File: rtl/alu_cmd_issue.sv
// ALU operand-issue stage: FIFO -> issue register -> result register, with
// optional forwarding of the previous result into operand 1.
module alu_cmd_issue
   import alu_issue_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned OP_W   = OP_W_DEF,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   alu_cmd_issue_if.slave         cmd_if,
   output logic [DATA_W-1:0]      alu_in_1,
   output logic [DATA_W-1:0]      alu_in_2,
   output logic [OP_W-1:0]        alu_op,
   input  logic [DATA_W-1:0]      alu_out_res,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic [CNT_W-1:0]       issued_cnt
);
   alu_cmd_t          push_cmd;
   alu_cmd_t          head;
   logic              push;
   logic              load;
   logic              cap;
   logic              empty_c;
   logic              full_c;
   logic              issue_valid;
   logic [DATA_W-1:0] last_res;
   logic [DATA_W-1:0] fwd_val;

   assign push_cmd = '{in_1: cmd_if.cmd_in_1, in_2: cmd_if.cmd_in_2,
                       op: cmd_if.cmd_op, fwd: cmd_if.cmd_fwd};

   assign cmd_if.cmd_ready = !full_c;
   assign push = cmd_if.cmd_valid && !full_c;
   assign cap  = issue_valid && (!cmd_if.res_valid || cmd_if.res_ready);
   assign load = !empty_c && (!issue_valid || cap);

   // A predecessor captured on this edge has not reached last_res yet.
   assign fwd_val = cap ? alu_out_res : last_res;

   alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .din     (push_cmd),
      .pop     (load),
      .dout    (head),
      .empty_c (empty_c),
      .full_c  (full_c),
      .count   (fifo_count)
   );

   // Result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_if.res_valid <= 1'b0;
         cmd_if.res_data  <= '0;
         last_res         <= '0;
      end else if (cap) begin
         cmd_if.res_valid <= 1'b1;
         cmd_if.res_data  <= alu_out_res;
         last_res         <= alu_out_res;
      end else if (cmd_if.res_valid && cmd_if.res_ready) begin
         cmd_if.res_valid <= 1'b0;
      end
   end

   // Issue register; operands hold their last values while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_valid <= 1'b0;
         alu_in_1    <= '0;
         alu_in_2    <= '0;
         alu_op      <= '0;
         issued_cnt  <= '0;
      end else if (load) begin
         issue_valid <= 1'b1;
         alu_in_1    <= head.fwd ? fwd_val : head.in_1;
         alu_in_2    <= head.in_2;
         alu_op      <= head.op;
         issued_cnt  <= issued_cnt + CNT_W'(1);
      end else if (cap) begin
         issue_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_alu_cmd_issue.sv
// Directed bench for alu_cmd_issue with a transaction-level result model.
module tb_alu_cmd_issue;
   import alu_issue_pkg::*;

   localparam int unsigned DW    = 32;
   localparam int unsigned OW    = 3;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = 16;
   localparam int unsigned FW    = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_cmd_issue_if cmd_if();
   logic [DW-1:0] alu_in_1, alu_in_2, alu_out_res;
   logic [OW-1:0] alu_op;
   logic [FW-1:0] fifo_count;
   logic [CW-1:0] issued_cnt;

   alu_cmd_issue #(.DATA_W(DW), .OP_W(OW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_if      (cmd_if.slave),
      .alu_in_1    (alu_in_1),
      .alu_in_2    (alu_in_2),
      .alu_op      (alu_op),
      .alu_out_res (alu_out_res),
      .fifo_count  (fifo_count),
      .issued_cnt  (issued_cnt)
   );

   function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [OW-1:0] op);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a ^ b;
         default: return a & b;
      endcase
   endfunction

   assign alu_out_res = alu_f(alu_in_1, alu_in_2, alu_op);

   int n_checks = 0;
   int n_errors = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   function automatic void fail_now(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: wait bound expired", name);
   endfunction

   // Model: every accepted command yields one result, in order; a forwarded
   // operand is the result of the command accepted just before it.
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] got[$];
   int            got_cyc[$];
   logic [DW-1:0] prev_res;
   int            n_push;
   int            cyc = 0;
   logic [DW-1:0] m_a, m_r, m_e;

   always @(negedge clk) begin
      cyc++;
      if (rst_n === 1'b1) begin
         chk("cmd_ready_vs_count", cmd_if.cmd_ready, fifo_count != FW'(DEPTH));
         if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
            m_a = cmd_if.cmd_fwd ? prev_res : cmd_if.cmd_in_1;
            m_r = alu_f(m_a, cmd_if.cmd_in_2, cmd_if.cmd_op);
            prev_res = m_r;
            exp_q.push_back(m_r);
            n_push++;
         end
         if (cmd_if.res_valid && cmd_if.res_ready) begin
            got.push_back(cmd_if.res_data);
            got_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL res_unexpected: got %0d, expected no result", cmd_if.res_data);
            end else begin
               m_e = exp_q.pop_front();
               chk("res_data", cmd_if.res_data, m_e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [OW-1:0] op, input logic fwd);
      int t;
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_in_1  = a;
      cmd_if.cmd_in_2  = b;
      cmd_if.cmd_op    = op;
      cmd_if.cmd_fwd   = fwd;
      t = 0;
      while (!cmd_if.cmd_ready && t < 50) begin
         tick();
         t++;
      end
      if (t >= 50) fail_now("send_timeout");
      else tick();
   endtask

   task automatic drain();
      int t;
      cmd_if.cmd_valid = 1'b0;
      t = 0;
      while ((exp_q.size() != 0 || cmd_if.res_valid) && t < 200) begin
         tick();
         t++;
      end
      if (t >= 200) fail_now("drain_timeout");
      repeat (2) tick();
      chk("no_extra_res", cmd_if.res_valid, 0);
      chk("drain_fifo_count", fifo_count, 0);
      chk("drain_issued_cnt", issued_cnt, CW'(n_push));
   endtask

   task automatic model_reset();
      exp_q.delete();
      prev_res = '0;
      n_push   = 0;
   endtask

   int r0;

   initial begin
      rst_n            = 1'b0;
      model_reset();
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_in_1  = 32'd5;
      cmd_if.cmd_in_2  = 32'd3;
      cmd_if.cmd_op    = 3'd0;
      cmd_if.cmd_fwd   = 1'b0;
      cmd_if.res_ready = 1'b1;
      repeat (3) tick();
      chk("rst_cmd_ready", cmd_if.cmd_ready, 1);
      chk("rst_res_valid", cmd_if.res_valid, 0);
      chk("rst_res_data", cmd_if.res_data, 0);
      chk("rst_alu_in_1", alu_in_1, 0);
      chk("rst_alu_in_2", alu_in_2, 0);
      chk("rst_alu_op", alu_op, 0);
      chk("rst_fifo_count", fifo_count, 0);
      chk("rst_issued_cnt", issued_cnt, 0);

      // Single command, accepted on the first edge after release.
      rst_n = 1'b1;
      tick();
      cmd_if.cmd_valid = 1'b0;
      chk("single_fifo_count", fifo_count, 1);
      chk("single_issued_pre", issued_cnt, 0);
      tick();
      chk("single_alu_in_1", alu_in_1, 5);
      chk("single_alu_in_2", alu_in_2, 3);
      chk("single_issued_cnt", issued_cnt, 1);
      chk("single_res_early", cmd_if.res_valid, 0);
      tick();
      chk("single_res_valid", cmd_if.res_valid, 1);
      chk("single_res_data", cmd_if.res_data, 8);
      drain();

      // Back-to-back burst: results one per cycle.
      r0 = got.size();
      for (int i = 0; i < 8; i++)
         send(DW'(i * 100 + 7), DW'(i + 1), OW'(i % 3), 1'b0);
      drain();
      chk("burst_count", got.size() - r0, 8);
      chk("burst_no_gaps", got_cyc[r0 + 7] - got_cyc[r0], 7);

      // Forward chain: back-to-back forwards, then one after an idle gap.
      r0 = got.size();
      send(32'd10, 32'd4, 3'd0, 1'b0);
      send(32'd99, 32'd1, 3'd0, 1'b1);
      send(32'd77, 32'd2, 3'd0, 1'b1);
      drain();
      repeat (3) tick();
      send(32'd0, 32'd5, 3'd0, 1'b1);
      drain();
      chk("fwd_r0", got[r0], 14);
      chk("fwd_r1", got[r0 + 1], 15);
      chk("fwd_r2", got[r0 + 2], 17);
      chk("fwd_r3_gap", got[r0 + 3], 22);

      // Back-pressure: fill result, issue and FIFO.
      r0 = got.size();
      cmd_if.res_ready = 1'b0;
      for (int i = 1; i <= 6; i++)
         send(DW'(1000 + i), DW'(i), 3'd0, 1'b0);
      chk("bp_fifo_full", fifo_count, 4);
      chk("bp_cmd_ready", cmd_if.cmd_ready, 0);
      chk("bp_res_valid", cmd_if.res_valid, 1);
      chk("bp_res_data", cmd_if.res_data, 1002);
      chk("bp_alu_in_1", alu_in_1, 1002);
      chk("bp_alu_in_2", alu_in_2, 2);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_in_1  = 32'd1007;
      cmd_if.cmd_in_2  = 32'd7;
      repeat (4) tick();
      chk("bp_hold_count", fifo_count, 4);
      chk("bp_hold_res", cmd_if.res_data, 1002);
      cmd_if.res_ready = 1'b1;
      send(32'd1007, 32'd7, 3'd0, 1'b0);
      drain();
      chk("bp_count", got.size() - r0, 7);
      chk("bp_first", got[r0], 1002);
      chk("bp_last", got[r0 + 6], 1014);

      // Reset mid-burst with three commands buffered.
      cmd_if.res_ready = 1'b0;
      for (int i = 1; i <= 5; i++)
         send(DW'(2000 + i), DW'(i), 3'd1, 1'b0);
      cmd_if.cmd_valid = 1'b0;
      chk("mid_fifo_count", fifo_count, 3);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("mid_rst_fifo_count", fifo_count, 0);
      chk("mid_rst_res_valid", cmd_if.res_valid, 0);
      chk("mid_rst_cmd_ready", cmd_if.cmd_ready, 1);
      chk("mid_rst_issued", issued_cnt, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      cmd_if.res_ready = 1'b1;
      r0 = got.size();
      send(32'd123, 32'd9, 3'd0, 1'b1);
      drain();
      chk("post_rst_fwd_zero", got[r0], 9);
      chk("post_rst_issued", issued_cnt, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule
